// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with registered ALU operands and a tagged valid/ready response channel.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 wins all contention.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   grant;
    logic   grant_vld;
    logic   accept;

    // Grant is only offered in IDLE, so ready can never depend on rsp_ready.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        grant_vld = 1'b0;
        grant     = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
                grant     = 1'b0;
`else
                grant     = ~last_grant;
`endif
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant     = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant     = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant && !Reset;
    assign req1_ready = grant_vld &&  grant && !Reset;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = EXEC;
            EXEC:                   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 3'b000;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                alu_a      <= grant ? req1_a  : req0_a;
                alu_b      <= grant ? req1_b  : req0_b;
                alu_op     <= grant ? req1_op : req0_op;
                last_grant <= grant;
            end
            // last_grant still holds the ID of the op now in the ALU.
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_id     <= last_grant;
                rsp_valid  <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the alu_* lines.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;

    logic             CLK = 1'b0;
    logic             Reset;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [2:0]       alu_op;
    logic             alu_zero;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [WIDTH-1:0] rsp_result;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .Reset(Reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    // Reference ALU the arbiter is meant to drive.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_b - alu_a;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a & alu_b;
            3'b101: alu_result = ~alu_a & alu_b;
            3'b110: alu_result = alu_a ^ alu_b;
            3'b111: alu_result = ~(alu_a ^ alu_b);
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One uncontended op with rsp_ready high: accept N, response N+2, gone N+3.
    task automatic run_single(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [2:0] op, input logic [WIDTH-1:0] exp_res, input logic exp_zero);
        @(negedge CLK);
        rsp_ready = 1'b1;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
        #1;
        check("accept_ready", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        check("other_ready",  {31'd0, id ? req0_ready : req1_ready}, 32'd0);
        @(negedge CLK);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("exec_alu_op", {29'd0, alu_op}, {29'd0, op});
        @(negedge CLK);
        check("rsp_valid",  {31'd0, rsp_valid}, 32'd1);
        check("rsp_result", rsp_result, exp_res);
        check("rsp_zero",   {31'd0, rsp_zero}, {31'd0, exp_zero});
        check("rsp_id",     {31'd0, rsp_id}, {31'd0, id});
        @(negedge CLK);
        check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    initial begin
        logic exp_id;
        Reset = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_op = 3'b011;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = 3'b011;
        rsp_ready  = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
        check("reset_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
        check("reset_alu_a",      alu_a, 32'd0);
        check("reset_alu_op",     {29'd0, alu_op}, 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        Reset = 1'b0;

        // Single op, zero flag, wrap-around.
        run_single(1'b0, 32'd5, 32'd3, 3'b001, 32'd2, 1'b0);
        run_single(1'b1, 32'h0F0F0F0F, 32'h0F0F0F0F, 3'b110, 32'd0, 1'b1);
        run_single(1'b0, 32'hFFFFFFFF, 32'd1, 3'b000, 32'd0, 1'b1);
        run_single(1'b1, 32'd1, 32'd0, 3'b010, 32'hFFFFFFFF, 1'b0);
        run_single(1'b0, 32'hF0, 32'h3C, 3'b101, 32'h0C, 1'b0);

        // Contention from reset: round-robin 0,1,0,1 (fixed priority: all 0).
        do_reset();
        @(negedge CLK);
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_op = 3'b000;
        req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd1; req1_op = 3'b000;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = k[0];
`endif
            #1;
            check("cont_req0_ready", {31'd0, req0_ready}, {31'd0, ~exp_id});
            check("cont_req1_ready", {31'd0, req1_ready}, {31'd0, exp_id});
            @(negedge CLK);
            @(negedge CLK);
            check("cont_rsp_id",     {31'd0, rsp_id}, {31'd0, exp_id});
            check("cont_rsp_result", rsp_result, exp_id ? 32'd21 : 32'd11);
            @(negedge CLK);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Back-pressure: response held four cycles, requester 0 waiting.
        @(negedge CLK);
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd2; req1_op = 3'b011;
        #1;
        check("bp_accept", {31'd0, req1_ready}, 32'd1);
        @(negedge CLK);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd8; req0_b = 32'd3; req0_op = 3'b100;
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            check("bp_rsp_valid",  {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_result", rsp_result, 32'd7);
            check("bp_rsp_id",     {31'd0, rsp_id}, 32'd1);
            check("bp_rsp_zero",   {31'd0, rsp_zero}, 32'd0);
            check("bp_ready",      {30'd0, req0_ready, req1_ready}, 32'd0);
            @(negedge CLK);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        check("bp_release_drop",  {31'd0, rsp_valid}, 32'd0);
        check("bp_release_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge CLK);
        req0_valid = 1'b0;
        @(negedge CLK);
        check("bp_next_result", rsp_result, 32'd0);
        check("bp_next_zero",   {31'd0, rsp_zero}, 32'd1);
        check("bp_next_id",     {31'd0, rsp_id}, 32'd0);
        @(negedge CLK);

        // Reset during EXEC of a requester-0 op: response discarded, 0 wins next.
        @(negedge CLK);
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5; req0_op = 3'b110;
        @(negedge CLK);
        req0_valid = 1'b0;
        check("mid_exec_alu_op", {29'd0, alu_op}, 32'd6);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_alu_op",    {29'd0, alu_op}, 32'd0);
        check("mid_alu_a",     alu_a, 32'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("mid_grant0", {31'd0, req0_ready}, 32'd1);
        check("mid_grant1", {31'd0, req1_ready}, 32'd0);
        @(negedge CLK);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge CLK);
        check("mid_after_id", {31'd0, rsp_id}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (3-bit op encoding, 32-bit operands, zero flag) between two requesters, e.g. the main datapath and a branch/address helper.
- Arbitrates with round-robin, drives the ALU operand and op lines from registers, and captures the result.
- Returns each result on a valid/ready response channel tagged with the requester ID.
- Sits between the requesters and the ALU instance. The ALU is wired with ALUSrcB=0, so this block's alu_b drives readData2.

Parameters:
- WIDTH, 32, operand/result width.

Ports:
- CLK  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  operand A
- req0_b  input  WIDTH  operand B
- req0_op  input  3  ALU op code
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
- alu_a  output  WIDTH  registered operand to ALU readData1
- alu_b  output  WIDTH  registered operand to ALU readData2
- alu_op  output  3  registered op to ALU ALUOp
- alu_result  input  WIDTH  ALU result
- alu_zero  input  1  ALU zero flag
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the op
- rsp_result  output  WIDTH  captured result
- rsp_zero  output  1  captured zero flag

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- State machine states: IDLE, EXEC, RESP.
- Reset values:
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - alu_a=0, alu_b=0, alu_op=3'b000.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
  - req0_ready=0 and req1_ready=0 while Reset is high.
- Op encoding driven to the ALU:
  - 000 a+b
  - 001 a-b
  - 010 b-a
  - 011 a|b
  - 100 a&b
  - 101 ~a&b
  - 110 a^b
  - 111 a~^b
  - The block passes op through unmodified and does no arithmetic itself.
- Grant:
  - Combinational, evaluated only in IDLE.
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high in any cycle.
  - Ready never depends on rsp_ready. There is no combinational path from rsp_ready to reqN_ready.
- IDLE, on accept (valid && ready):
  - Latch the granted requester's a/b/op into alu_a/alu_b/alu_op.
  - Record the ID and set last_grant=ID.
  - Next state EXEC.
- IDLE, no valid: stay in IDLE. alu_* hold their previous values.
- EXEC (exactly 1 cycle):
  - Capture alu_result and alu_zero into rsp_result and rsp_zero; set rsp_id.
  - Set rsp_valid=1. Next state RESP.
- RESP:
  - rsp_valid stays high. rsp_* are stable until the handshake.
  - On rsp_valid && rsp_ready: rsp_valid=0 next cycle, next state IDLE.
  - No new request is accepted while in EXEC or RESP.
- Latency and throughput:
  - Accept in cycle N gives rsp_valid high in cycle N+2.
  - With rsp_ready tied high, rsp_valid is low again at N+3.
  - Maximum throughput is 1 op per 3 cycles.
- Requester protocol: reqN_valid may drop without being accepted, and the arbiter ignores it. Once valid is asserted, a/b/op need only be stable in the accept cycle.
- Width: WIDTH-bit wrap-around arithmetic, performed by the ALU. No overflow flag.
- Reset mid-operation: any latched or pending response is discarded, rsp_valid drops, and all reset values apply at the next edge.
- Back-to-back contention: both requesters held valid alternate grants 0,1,0,1… starting with 0 after reset.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both are valid. last_grant is still recorded but not used for arbitration.
- Undefined: round-robin as specified above.

Test Plan:
- Single op: req0 a=5, b=3, op=001, rsp_ready=1 → req0_ready high in the accept cycle; rsp_valid 2 cycles later; rsp_result=2, rsp_zero=0, rsp_id=0.
- Zero flag: req1 a=0x0F0F0F0F, b=0x0F0F0F0F, op=110 → rsp_result=0, rsp_zero=1, rsp_id=1.
- Contention: both valid continuously, each a=i, b=1, op=000 → grants and rsp_id sequence 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN defined → all 0.
- Back-pressure: rsp_ready=0 for 4 cycles after rsp_valid → rsp_result, rsp_id, rsp_zero stable and both reqN_ready low. Release → rsp_valid low the next cycle, then a new accept.
- Wrap-around: a=0xFFFFFFFF, b=1, op=000 → rsp_result=0, rsp_zero=1. op=010 with a=1, b=0 → rsp_result=0xFFFFFFFF.
- Reset mid-op: assert Reset in the EXEC cycle → next cycle rsp_valid=0, alu_op=000; the first following contended grant goes to requester 0.
